// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin 2:1 mux arbiter.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic SEL_CH1 = 1'b0;
  localparam logic SEL_CH2 = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle: two upstream valid/ready requesters, one downstream consumer, select/status.
interface mux_rr_arbiter_if #(
  parameter int P_WIDTH = 8
);

  logic               i_valid1;
  logic [P_WIDTH-1:0] i_data1;
  logic               i_last1;
  logic               o_ready1;

  logic               i_valid2;
  logic [P_WIDTH-1:0] i_data2;
  logic               i_last2;
  logic               o_ready2;

  logic               o_valid;
  logic [P_WIDTH-1:0] o_data;
  logic               o_last;
  logic               i_ready;

  logic               o_sel;
  logic               o_busy;

  modport slave (
    input  i_valid1, i_data1, i_last1,
    input  i_valid2, i_data2, i_last2,
    input  i_ready,
    output o_ready1, o_ready2,
    output o_valid, o_data, o_last,
    output o_sel, o_busy
  );

  modport master (
    output i_valid1, i_data1, i_last1,
    output i_valid2, i_data2, i_last2,
    output i_ready,
    input  o_ready1, o_ready2,
    input  o_valid, o_data, o_last,
    input  o_sel, o_busy
  );

endinterface

// File: rtl/mux_rr_arbiter_out_stage.sv
// One-entry valid/ready holding register feeding the downstream consumer.
module mux_arb_out_stage #(
  parameter int P_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [P_WIDTH-1:0] i_data,
  input  logic               i_last,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_last
);

  logic               valid_q, valid_d;
  logic [P_WIDTH-1:0] data_q, data_d;
  logic               last_q, last_d;

  // A load wins over a drain, so a simultaneous drain+load keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
      last_d  = i_last;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 2:1 datapath mux; locks the grant for a burst
// ending on the owner's last flag or at the beat cap.
module mux_rr_arbiter #(
  parameter int P_WIDTH     = 8,
  parameter int P_MAX_BEATS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mux_rr_arbiter_if.slave      bus
);

  import mux_rr_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] CapLast = CNT_W'(P_MAX_BEATS - 1);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;

  logic               outValid;
  logic               outLast;
  logic [P_WIDTH-1:0] outData;

  logic               isBusy;
  logic               slotFree;
  logic               ownerValid;
  logic               ownerLast;
  logic [P_WIDTH-1:0] ownerData;
  logic               accept;
  logic               releaseGrant;

  assign isBusy       = (state_q == ST_BUSY);
  assign slotFree     = !outValid || bus.i_ready;
  assign ownerValid   = (owner_q == SEL_CH2) ? bus.i_valid2 : bus.i_valid1;
  assign ownerLast    = (owner_q == SEL_CH2) ? bus.i_last2  : bus.i_last1;
  assign ownerData    = (owner_q == SEL_CH2) ? bus.i_data2  : bus.i_data1;
  assign accept       = isBusy && ownerValid && slotFree;
  assign releaseGrant = accept && (ownerLast || (beatCnt_q == CapLast));

  // Owner is only updated on a new grant, so the select holds its value while idle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid1 || bus.i_valid2) begin
          state_d   = ST_BUSY;
          beatCnt_d = '0;
          if (bus.i_valid1 && bus.i_valid2) begin
            owner_d = prio_q;
          end else begin
            owner_d = bus.i_valid2 ? SEL_CH2 : SEL_CH1;
          end
        end
      end
      ST_BUSY: begin
        if (accept) begin
          beatCnt_d = beatCnt_q + 1'b1;
        end
        if (releaseGrant) begin
          state_d = ST_IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= SEL_CH1;
      prio_q    <= SEL_CH1;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  mux_arb_out_stage #(
    .P_WIDTH(P_WIDTH)
  ) u_outStage (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (accept),
    .i_data (ownerData),
    .i_last (ownerLast),
    .i_ready(bus.i_ready),
    .o_valid(outValid),
    .o_data (outData),
    .o_last (outLast)
  );

  assign bus.o_ready1 = isBusy && (owner_q == SEL_CH1) && slotFree;
  assign bus.o_ready2 = isBusy && (owner_q == SEL_CH2) && slotFree;
  assign bus.o_valid  = outValid;
  assign bus.o_data   = outData;
  assign bus.o_last   = outLast;
  assign bus.o_sel    = owner_q;
  assign bus.o_busy   = isBusy;

endmodule
